fetch_ctrl: RTL

//  Instruction-fetch sequencer for the RV32I 5-stage pipeline. Owns the PC register and

---
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one outstanding imem request at a time and fills a single IF slot.
// Optional stall counter output fetch_stall_cnt is built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_stall_cnt
`endif
);

    // Handshakes: imem request is accepted on a cycle with imem_req && imem_gnt;
    // imem_rvalid returns exactly one response per accepted request, in order.
    // IF slot transfers to decode on a cycle with if_valid && id_ready.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        slot_free;
    logic        fire;
    logic        load;

    assign slot_free = !if_valid || id_ready;
    assign fire      = imem_req && imem_gnt;
    // A response that arrives together with a redirect is stale and never loads.
    assign load      = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (fire) begin
                    state_d = redirect_valid ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = (state_q == S_REQ) && slot_free;
        imem_addr = pc_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                pc_q <= {redirect_pc[31:2], 2'b00};
            end else if (fire) begin
                pc_q <= pc_q + 32'd4;
            end
            if (fire) begin
                req_pc_q <= pc_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if_valid <= 1'b0;
            if_pc    <= 32'h0000_0000;
            if_instr <= 32'h0000_0013;
        end else begin
            if (redirect_valid) begin
                if_valid <= 1'b0;
            end else if (load) begin
                if_valid <= 1'b1;
            end else if (id_ready) begin
                if_valid <= 1'b0;
            end
            if (load) begin
                if_pc    <= req_pc_q;
                if_instr <= imem_rdata;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_stall_cnt <= 32'h0000_0000;
        end else if ((state_q != S_IDLE) && !if_valid && (fetch_stall_cnt != 32'hFFFF_FFFF)) begin
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
        end
    end
`endif

endmodule
